m_axis_pkt_tx: RTL and testbench



---
 rtl/axis_pkt_pkg.sv | 28 ++
 rtl/m_axis_pkt_tx_if.sv | 14 +
 rtl/m_axis_pkt_tx_beat_gather.sv | 42 ++++
 rtl/m_axis_pkt_tx.sv | 145 ++++++++++++++
 tb/tb_m_axis_pkt_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the packet-buffer-to-AXI4-Stream transmit path.
package axis_pkt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      DONE,
      RELEASE
   } tx_state_t;

   localparam int BYTES_PER_BEAT = 4;
   localparam int KEEP_W         = 4;

   // LSB-aligned byte enables for a beat carrying nbytes valid bytes.
   function automatic logic [KEEP_W-1:0] keep_from_count(input logic [2:0] nbytes);
      logic [KEEP_W-1:0] keep;
      case (nbytes)
         3'd0:    keep = 4'b0000;
         3'd1:    keep = 4'b0001;
         3'd2:    keep = 4'b0011;
         3'd3:    keep = 4'b0111;
         default: keep = 4'b1111;
      endcase
      return keep;
   endfunction

endpackage

// File: rtl/m_axis_pkt_tx_if.sv
// 32-bit AXI4-Stream bundle with tkeep/tlast; master drives data, slave drives tready.
interface m_axis_pkt_tx_if;
   import axis_pkt_pkg::*;

   logic [8*BYTES_PER_BEAT-1:0] tdata;
   logic [KEEP_W-1:0]           tkeep;
   logic                        tvalid;
   logic                        tlast;
   logic                        tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/m_axis_pkt_tx_beat_gather.sv
// Combinational beat former: picks up to four bytes at rd_ptr_i and zeroes every lane
// that lies past the beat length, past the real data, or outside the buffer array.
module pkt_beat_gather
   import axis_pkt_pkg::*;
#(
   parameter int FIFO_SIZE      = 1024,
   parameter int FIFO_ADDR_SIZE = 16
) (
   input  logic [7:0]                  pkt_data_i [FIFO_SIZE],
   input  logic [FIFO_ADDR_SIZE-1:0]   rd_ptr_i,
   input  logic [FIFO_ADDR_SIZE-1:0]   len_i,
   input  logic [FIFO_ADDR_SIZE-1:0]   data_len_i,
   output logic [8*BYTES_PER_BEAT-1:0] tdata_o,
   output logic [KEEP_W-1:0]           tkeep_o,
   output logic                        tlast_o
);

   localparam int IDX_W = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
   localparam logic [FIFO_ADDR_SIZE-1:0] SIZE_A = FIFO_ADDR_SIZE'(FIFO_SIZE);
   localparam logic [FIFO_ADDR_SIZE-1:0] BEAT_A = FIFO_ADDR_SIZE'(BYTES_PER_BEAT);

   logic [FIFO_ADDR_SIZE-1:0] rem;
   logic [2:0]                nbytes;

   // Saturate at zero so a pointer at or past the end never wraps into a huge remainder.
   assign rem     = (rd_ptr_i < len_i) ? (len_i - rd_ptr_i) : '0;
   assign nbytes  = (rem >= BEAT_A) ? 3'd4 : rem[2:0];
   assign tkeep_o = keep_from_count(nbytes);
   assign tlast_o = (rem <= BEAT_A);

   generate
      for (genvar gi = 0; gi < BYTES_PER_BEAT; gi++) begin : g_lane
         logic [FIFO_ADDR_SIZE-1:0] idx;
         logic                      lane_on;

         assign idx     = rd_ptr_i + FIFO_ADDR_SIZE'(gi);
         assign lane_on = (3'(gi) < nbytes) && (idx < data_len_i) && (idx < SIZE_A);
         assign tdata_o[8*gi +: 8] = lane_on ? pkt_data_i[idx[IDX_W-1:0]] : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/m_axis_pkt_tx.sv
// Streams a completed packet from the receive buffer out as 32-bit AXI4-Stream, then
// pulses pkt_done_o to flush the buffer. Zero-padding to MIN_FRAME is enabled by PAD_TO_MIN_EN.
module m_axis_pkt_tx
   import axis_pkt_pkg::*;
#(
   parameter int FIFO_SIZE      = 1024,
   parameter int FIFO_ADDR_SIZE = 16,
   parameter int MIN_FRAME      = 60
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [7:0]                pkt_data_i [FIFO_SIZE],
   input  logic [FIFO_ADDR_SIZE-1:0] pkt_len_i,
   input  logic                      pkt_valid_i,
   output logic                      pkt_done_o,
   output logic                      busy_o,
   m_axis_pkt_tx_if.master           m_axis
);

`ifdef PAD_TO_MIN_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam logic [FIFO_ADDR_SIZE-1:0] SIZE_A = FIFO_ADDR_SIZE'(FIFO_SIZE);
   localparam logic [FIFO_ADDR_SIZE-1:0] MIN_A  = FIFO_ADDR_SIZE'(MIN_FRAME);
   localparam logic [FIFO_ADDR_SIZE-1:0] BEAT_A = FIFO_ADDR_SIZE'(BYTES_PER_BEAT);

   tx_state_t                   state_q;
   logic [FIFO_ADDR_SIZE-1:0]   rd_ptr_q;
   logic [FIFO_ADDR_SIZE-1:0]   rd_ptr_d;
   logic [FIFO_ADDR_SIZE-1:0]   len_q;
   logic [FIFO_ADDR_SIZE-1:0]   dlen_q;
   logic [8*BYTES_PER_BEAT-1:0] tdata_q;
   logic [KEEP_W-1:0]           tkeep_q;
   logic                        tvalid_q;
   logic                        tlast_q;
   logic                        pkt_done_q;
   logic                        busy_q;

   logic [FIFO_ADDR_SIZE-1:0]   clamped_len;
   logic [FIFO_ADDR_SIZE-1:0]   emit_len;
   logic [FIFO_ADDR_SIZE-1:0]   gather_ptr;
   logic [8*BYTES_PER_BEAT-1:0] g_tdata;
   logic [KEEP_W-1:0]           g_tkeep;
   logic                        g_tlast;

   assign clamped_len = (pkt_len_i > SIZE_A) ? SIZE_A : pkt_len_i;
   assign emit_len    = (PAD_EN && (clamped_len < MIN_A)) ? MIN_A : clamped_len;

   // In SEND the gather looks one beat ahead so the next beat loads on the handshake edge.
   assign rd_ptr_d   = rd_ptr_q + BEAT_A;
   assign gather_ptr = (state_q == SEND) ? rd_ptr_d : rd_ptr_q;

   pkt_beat_gather #(
      .FIFO_SIZE      (FIFO_SIZE),
      .FIFO_ADDR_SIZE (FIFO_ADDR_SIZE)
   ) u_gather (
      .pkt_data_i (pkt_data_i),
      .rd_ptr_i   (gather_ptr),
      .len_i      (len_q),
      .data_len_i (dlen_q),
      .tdata_o    (g_tdata),
      .tkeep_o    (g_tkeep),
      .tlast_o    (g_tlast)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         dlen_q     <= '0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         pkt_done_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pkt_valid_i) begin
                  len_q    <= emit_len;
                  dlen_q   <= clamped_len;
                  rd_ptr_q <= '0;
                  busy_q   <= 1'b1;
                  if (emit_len == '0) begin
                     state_q    <= DONE;
                     pkt_done_q <= 1'b1;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               tdata_q  <= g_tdata;
               tkeep_q  <= g_tkeep;
               tlast_q  <= g_tlast;
               tvalid_q <= 1'b1;
               state_q  <= SEND;
            end
            SEND: begin
               if (m_axis.tready) begin
                  if (tlast_q) begin
                     tvalid_q   <= 1'b0;
                     state_q    <= DONE;
                     pkt_done_q <= 1'b1;
                  end else begin
                     rd_ptr_q <= rd_ptr_d;
                     tdata_q  <= g_tdata;
                     tkeep_q  <= g_tkeep;
                     tlast_q  <= g_tlast;
                  end
               end
            end
            DONE: begin
               state_q <= RELEASE;
            end
            RELEASE: begin
               // Hold off until the buffer has flushed so the same packet is not re-sent.
               if (!pkt_valid_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               tvalid_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign pkt_done_o    = pkt_done_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_m_axis_pkt_tx.sv
// Scoreboard bench for m_axis_pkt_tx: expected beats are queued per packet and
// popped by a monitor on each accepted beat. Honours PAD_TO_MIN_EN in its model.
module tb_m_axis_pkt_tx;
   import axis_pkt_pkg::*;

   localparam int FIFO_SIZE = 1024;
   localparam int ADDR_W    = 16;
   localparam int MIN_FRAME = 60;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [7:0]        pkt_data [FIFO_SIZE];
   logic [ADDR_W-1:0] pkt_len = '0;
   logic              pkt_valid = 1'b0;
   logic              pkt_done;
   logic              busy;

   m_axis_pkt_tx_if axis_if ();

   m_axis_pkt_tx #(
      .FIFO_SIZE      (FIFO_SIZE),
      .FIFO_ADDR_SIZE (ADDR_W),
      .MIN_FRAME      (MIN_FRAME)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .pkt_data_i  (pkt_data),
      .pkt_len_i   (pkt_len),
      .pkt_valid_i (pkt_valid),
      .pkt_done_o  (pkt_done),
      .busy_o      (busy),
      .m_axis      (axis_if)
   );

   always #5 aclk = ~aclk;

   beat_t exp_q[$];
   beat_t mon_e;
   beat_t stall_beat;
   int    n_tests = 0;
   int    n_fail = 0;
   int    done_cnt = 0;
   int    beat_cnt = 0;
   int    rdy_mode = 0;
   int    rdy_cyc = 0;
   bit    last_hs_prev = 1'b0;
   bit    stall_prev = 1'b0;
   bit    done_prev = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge aclk) begin
      if (!aresetn) begin
         last_hs_prev = 1'b0;
         stall_prev   = 1'b0;
         done_prev    = 1'b0;
      end else begin
         if (last_hs_prev) check_val("done_after_last", pkt_done, 1);
         if (done_prev)    check_val("done_width", pkt_done, 0);
         if (stall_prev) begin
            check_val("stall_valid", axis_if.tvalid, 1);
            check_val("stall_data", axis_if.tdata, stall_beat.data);
            check_val("stall_keep", axis_if.tkeep, stall_beat.keep);
            check_val("stall_last", axis_if.tlast, stall_beat.last);
         end
         if (pkt_done) done_cnt++;
         last_hs_prev = 1'b0;
         if (axis_if.tvalid && axis_if.tready) begin
            if (exp_q.size() == 0) begin
               check_val("extra_beat", axis_if.tvalid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("beat_data", axis_if.tdata, mon_e.data);
               check_val("beat_keep", axis_if.tkeep, mon_e.keep);
               check_val("beat_last", axis_if.tlast, mon_e.last);
               $display("[TB] beat data=%08h keep=%h last=%0d", axis_if.tdata,
                        axis_if.tkeep, axis_if.tlast);
            end
            last_hs_prev = axis_if.tlast;
            beat_cnt++;
         end
         stall_prev = axis_if.tvalid && !axis_if.tready;
         if (stall_prev) stall_beat = '{axis_if.tdata, axis_if.tkeep, axis_if.tlast};
         done_prev = pkt_done;
      end
   end

   task automatic fill_data(input int len, input logic [7:0] seed);
      for (int i = 0; i < FIFO_SIZE; i++)
         pkt_data[i] = (i < len) ? 8'(seed + 8'(i)) : (8'hA5 ^ 8'(i * 7));
   endtask

   // Reference model: exact (or padded) length, out-of-data bytes zero.
   task automatic push_expected(input int len, output int tot);
      int    dlen;
      int    n;
      beat_t b;
      dlen = (len > FIFO_SIZE) ? FIFO_SIZE : len;
      tot  = dlen;
`ifdef PAD_TO_MIN_EN
      if (tot < MIN_FRAME) tot = MIN_FRAME;
`endif
      for (int p = 0; p < tot; p += 4) begin
         n = (tot - p > 4) ? 4 : (tot - p);
         b = '0;
         for (int k = 0; k < 4; k++) begin
            if (k < n) begin
               b.keep[k] = 1'b1;
               if (p + k < dlen) b.data[8*k +: 8] = pkt_data[p + k];
            end
         end
         b.last = (tot - p <= 4);
         exp_q.push_back(b);
      end
   endtask

   task automatic drive_ready();
      case (rdy_mode)
         1:       axis_if.tready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
         default: axis_if.tready = 1'b1;
      endcase
      rdy_cyc++;
   endtask

   task automatic send_pkt(input int len, input logic [7:0] seed, input int mode, input int hold);
      int tot;
      int d0;
      int b0;
      int cyc;
      fill_data(len, seed);
      push_expected(len, tot);
      pkt_len = ADDR_W'(len);
      rdy_mode = mode;
      rdy_cyc = 0;
      axis_if.tready = 1'b1;
      d0 = done_cnt;
      b0 = beat_cnt;
      @(posedge aclk); #1;
      pkt_valid = 1'b1;
      if (tot > 0) begin
         @(posedge aclk); #1;
         check_val("lat_load", axis_if.tvalid, 0);
         @(posedge aclk); #1;
         check_val("lat_first", axis_if.tvalid, 1);
      end
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(posedge aclk); #1;
         drive_ready();
         cyc++;
      end
      axis_if.tready = 1'b1;
      check_val("done_count", done_cnt - d0, 1);
      check_val("queue_empty", exp_q.size(), 0);
      check_val("beat_count", beat_cnt - b0, (tot + 3) / 4);
      repeat (hold) @(posedge aclk);
      #1;
      check_val("release_busy", busy, 1);
      check_val("release_tvalid", axis_if.tvalid, 0);
      check_val("release_no_resend", done_cnt - d0, 1);
      pkt_valid = 1'b0;
      @(posedge aclk); #1;
      check_val("idle_busy", busy, 0);
      $display("[TB] packet len=%0d emitted=%0d beats=%0d mode=%0d", len, tot, beat_cnt - b0, mode);
      exp_q.delete();
   endtask

   task automatic reset_mid_packet();
      int tot;
      int b0;
      int d0;
      int cyc;
      fill_data(32, 8'h40);
      push_expected(32, tot);
      pkt_len = ADDR_W'(32);
      rdy_mode = 0;
      axis_if.tready = 1'b1;
      b0 = beat_cnt;
      d0 = done_cnt;
      @(posedge aclk); #1;
      pkt_valid = 1'b1;
      cyc = 0;
      while (beat_cnt - b0 < 2 && cyc < 100) begin
         @(posedge aclk); #1;
         cyc++;
      end
      check_val("rst_beats_before", beat_cnt - b0, 2);
      aresetn = 1'b0;
      pkt_valid = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      check_val("rst_tvalid", axis_if.tvalid, 0);
      check_val("rst_busy", busy, 0);
      exp_q.delete();
      repeat (6) @(posedge aclk);
      #1;
      check_val("rst_no_done", done_cnt - d0, 0);
      $display("[TB] packet len=32 aborted by reset after %0d beats", beat_cnt - b0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_data(0, 8'h00);
      axis_if.tready = 1'b1;
      aresetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check_val("reset_tvalid", axis_if.tvalid, 0);
      check_val("reset_tlast", axis_if.tlast, 0);
      check_val("reset_tkeep", axis_if.tkeep, 0);
      check_val("reset_tdata", axis_if.tdata, 0);
      check_val("reset_done", pkt_done, 0);
      check_val("reset_busy", busy, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      send_pkt(8, 8'h01, 0, 0);
      send_pkt(5, 8'h01, 0, 0);
      send_pkt(13, 8'h20, 1, 0);
      send_pkt(0, 8'h00, 0, 3);
      send_pkt(16, 8'h30, 0, 5);
      send_pkt(9, 8'h50, 0, 0);
      reset_mid_packet();
      send_pkt(32, 8'h60, 0, 0);
      send_pkt(2000, 8'h70, 0, 0);
      send_pkt(10, 8'h01, 0, 0);
      for (int r = 0; r < 4; r++)
         send_pkt(int'($urandom_range(1, 40)), 8'($urandom), int'($urandom_range(0, 1)), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
